// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_arbiter: message-granular round-robin share of one UART transmitter|
// | Optional tx_done watchdog via UART_TX_ARB_WDOG_EN.  Rev 1.0                |
// +--------------------------------------------------------------------------+
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WDOG_CYCLES = 2_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       enable_tx,
  output logic [7:0]                 tx_data,
  input  logic                       tx_done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       locked,
  output logic                       wdog_err
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           last_q, last_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic           locked_q, locked_d;

  logic [IDW-1:0] sel;
  logic           any_elig;
  logic [7:0]     sel_data;
  logic [IDW-1:0] next_ptr;

`ifdef UART_TX_ARB_WDOG_EN
  localparam int WDW = $clog2(WDOG_CYCLES + 1);
  logic [WDW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic           wdog_err_q, wdog_err_d;
`endif

  // Locked: only the owner may continue. Unlocked: first valid from rr_ptr upward.
  always_comb begin
    int idx;
    idx      = 0;
    sel      = grant_id_q;
    any_elig = 1'b0;
    if (locked_q) begin
      any_elig = req_valid[grant_id_q];
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (req_valid[IDW'(idx)]) begin
          sel      = IDW'(idx);
          any_elig = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_data = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state_q == IDLE) && any_elig && (sel == IDW'(i));
      if (sel == IDW'(i)) sel_data = req_data[8*i +: 8];
    end
  end

  assign next_ptr = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    last_d     = last_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    locked_d   = locked_q;
    enable_tx  = 1'b0;
`ifdef UART_TX_ARB_WDOG_EN
    wdog_cnt_d = wdog_cnt_q;
    wdog_err_d = wdog_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_elig) begin
          tx_data_d  = sel_data;
          last_d     = req_last[sel];
          grant_id_d = sel;
          locked_d   = 1'b1;
          state_d    = START;
        end
      end
      START: begin
        enable_tx = 1'b1;
        state_d   = WAIT;
`ifdef UART_TX_ARB_WDOG_EN
        wdog_cnt_d = '0;
`endif
      end
      WAIT: begin
        if (tx_done) begin
          state_d = IDLE;
          if (last_q) begin
            locked_d = 1'b0;
            rr_ptr_d = next_ptr;
          end
        end
`ifdef UART_TX_ARB_WDOG_EN
        else if (wdog_cnt_q == WDW'(WDOG_CYCLES - 1)) begin
          // Abandon the owner; any remaining bytes form a new message.
          wdog_err_d = 1'b1;
          locked_d   = 1'b0;
          rr_ptr_d   = next_ptr;
          state_d    = IDLE;
        end else begin
          wdog_cnt_d = wdog_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_data_q  <= 8'h00;
      last_q     <= 1'b0;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      locked_q   <= 1'b0;
`ifdef UART_TX_ARB_WDOG_EN
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      last_q     <= last_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      locked_q   <= locked_d;
`ifdef UART_TX_ARB_WDOG_EN
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
`endif
    end
  end

  assign tx_data  = tx_data_q;
  assign busy     = (state_q != IDLE);
  assign grant_id = grant_id_q;
  assign locked   = locked_q;
`ifdef UART_TX_ARB_WDOG_EN
  assign wdog_err = wdog_err_q;
`else
  assign wdog_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// Bench for uart_tx_arbiter: requester sources and a UART model feed a
// {grant,byte} scoreboard; directed steps cover arbitration, locking and reset.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 enable_tx;
  logic [7:0]           tx_data;
  logic                 tx_done;
  logic                 busy;
  logic [IDW-1:0]       grant_id;
  logic                 locked;
  logic                 wdog_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .WDOG_CYCLES(100)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .enable_tx(enable_tx), .tx_data(tx_data),
    .tx_done(tx_done), .busy(busy), .grant_id(grant_id),
    .locked(locked), .wdog_err(wdog_err)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } src_t;

  src_t        src_q[NUM_REQ][$];
  logic [9:0]  exp_q[$];   // {grant, byte}
  logic [10:0] obs_q[$];   // {held, grant, byte}
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_pulses = 0;
  bit          uart_auto = 1'b1;
  int          uart_delay = 3;
  bit          ready_bad = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic src(input int r, input string s, input bit last_end);
    for (int i = 0; i < s.len(); i++) begin
      src_t e;
      e.d = s[i];
      e.l = last_end && (i == s.len() - 1);
      src_q[r].push_back(e);
    end
  endtask

  task automatic expect_bytes(input int r, input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back({IDW'(r), s[i]});
  endtask

  function automatic bit pending();
    for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic source_loop();
    logic [NUM_REQ-1:0] acc;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (src_q[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = src_q[i][0].d;
          req_last[i]        = src_q[i][0].l;
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
      #1;
      acc = req_valid & req_ready;
      if ($countones(req_ready) > 1 || (busy && req_ready != '0)) ready_bad = 1'b1;
      @(posedge clk);
      if (!rst)
        for (int i = 0; i < NUM_REQ; i++) if (acc[i]) void'(src_q[i].pop_front());
    end
  endtask

  task automatic uart_loop();
    logic [7:0]     cap;
    logic [IDW-1:0] g;
    logic           held;
    forever begin
      @(negedge clk);
      if (enable_tx === 1'b1) begin
        n_pulses++;
        cap  = tx_data;
        g    = grant_id;
        held = 1'b1;
        if (uart_auto) begin
          repeat (uart_delay) begin
            @(negedge clk);
            if (tx_data !== cap) held = 1'b0;
          end
          tx_done = 1'b1;
          @(negedge clk);
          tx_done = 1'b0;
        end
        obs_q.push_back({held, g, cap});
      end
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int          n;
    logic [9:0]  e;
    logic [10:0] o;
    n = 0;
    while (n < budget && (pending() || exp_q.size() > obs_q.size() || busy)) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < budget), 1);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({tag, "_byte"}, o[7:0], e[7:0]);
      chk({tag, "_grant"}, o[9:8], e[9:8]);
      chk({tag, "_hold"}, o[10], 1);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic wait_en(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (enable_tx !== 1'b1 && n < 100);
    chk({tag, "_en_timeout"}, 32'(n < 100), 1);
  endtask

  initial begin
    int  p0;
    bit  r3;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_done   = 1'b0;
    fork
      source_loop();
      uart_loop();
    join_none

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_enable", enable_tx, 0);
    chk("rst_txdata", tx_data, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_locked", locked, 0);
    chk("rst_wdog", wdog_err, 0);
    rst = 1'b0;

    // Four-byte message from requester 0
    src(0, "OK\015\012", 1'b1);
    expect_bytes(0, "OK\015\012");
    p0 = n_pulses;
    drain("t1", 400);
    chk("t1_pulses", n_pulses - p0, 4);
    chk("t1_locked", locked, 0);
    chk("t1_rr", dut.rr_ptr_q, 1);

    src(3, "!", 1'b1);
    expect_bytes(3, "!");
    drain("t1b", 100);
    chk("t1b_rr_wrap", dut.rr_ptr_q, 0);

    // Two contenders, whole messages, no interleave
    src(0, "abc", 1'b1);
    src(2, "xyz", 1'b1);
    expect_bytes(0, "abc");
    expect_bytes(2, "xyz");
    drain("t2", 600);
    chk("t2_rr", dut.rr_ptr_q, 3);

    src(3, "#", 1'b1);
    expect_bytes(3, "#");
    drain("t2b", 100);
    src(1, "P", 1'b1);
    src(3, "Q", 1'b1);
    expect_bytes(1, "P");
    expect_bytes(3, "Q");
    drain("t2c", 300);
    chk("t2c_rr", dut.rr_ptr_q, 0);

    // Owner pauses mid-message; requester 3 must be starved
    src(1, "A", 1'b0);
    expect_bytes(1, "A");
    drain("t3a", 100);
    chk("t3_locked", locked, 1);
    chk("t3_grant", grant_id, 1);
    src(3, "Z", 1'b1);
    r3 = 1'b0;
    repeat (50) begin
      @(negedge clk);
      #2;
      if (req_ready[3] || busy) r3 = 1'b1;
    end
    chk("t3_starve", r3, 0);
    chk("t3_still_locked", locked, 1);
    src(1, "BC", 1'b1);
    expect_bytes(1, "BC");
    expect_bytes(3, "Z");
    drain("t3b", 600);

    // tx_done during START must be ignored
    uart_auto = 1'b0;
    src(0, "M", 1'b1);
    expect_bytes(0, "M");
    wait_en("t4");
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    repeat (5) @(negedge clk);
    chk("t4_still_wait", busy, 1);
    chk("t4_locked", locked, 1);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    @(negedge clk);
    chk("t4_idle", busy, 0);
    chk("t4_unlocked", locked, 0);
    drain("t4", 50);

    // Asynchronous reset while in WAIT
    src(2, "R", 1'b1);
    expect_bytes(2, "R");
    wait_en("t5");
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_locked", locked, 0);
    chk("t5_grant", grant_id, 0);
    chk("t5_txdata", tx_data, 0);
    chk("t5_enable", enable_tx, 0);
    chk("t5_ready", req_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drain("t5a", 50);
    uart_auto = 1'b1;
    src(0, "U", 1'b1);
    src(3, "V", 1'b1);
    expect_bytes(0, "U");
    expect_bytes(3, "V");
    drain("t5b", 400);

`ifdef UART_TX_ARB_WDOG_EN
    begin
      int n;
      uart_auto = 1'b0;
      src(1, "W", 1'b0);
      src(2, "X", 1'b1);
      expect_bytes(1, "W");
      expect_bytes(2, "X");
      wait_en("t6");
      n = 0;
      while (wdog_err !== 1'b1 && n < 300) begin
        @(negedge clk);
        n++;
      end
      chk("t6_wdog_cycles", n - 1, 100);
      chk("t6_idle", busy, 0);
      chk("t6_unlocked", locked, 0);
      uart_auto = 1'b1;
      drain("t6", 300);
      chk("t6_sticky", wdog_err, 1);
    end
`else
    chk("wdog_tied", wdog_err, 0);
`endif

    chk("ready_onehot_idle", ready_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART transmitter among NUM_REQ byte-stream requesters.
- The UART uses a start-pulse/done-pulse interface: enable_tx, tx_data and tx_done.
- Grants are message-granular. Once a requester is granted, it keeps the UART until its byte tagged req_last has completed, so messages never interleave on the serial line.
- Sits between application producers (banner generator, status reporter, debug echo) and the existing uart instance.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- WDOG_CYCLES, 2_000_000: tx_done timeout in clk cycles. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte available.
- req_data  in  8*NUM_REQ  requester i byte at bits [8i+7:8i].
- req_last  in  NUM_REQ  byte is the final byte of its message.
- req_ready  out  NUM_REQ  byte accepted when valid&ready are both high at a clk edge.
- enable_tx  out  1  one-cycle start pulse to the UART.
- tx_data  out  8  byte to the UART; held stable from the enable_tx cycle until tx_done.
- tx_done  in  1  one-cycle completion pulse from the UART.
- busy  out  1  state != IDLE.
- grant_id  out  $clog2(NUM_REQ)  current or most recent owner.
- locked  out  1  a message is in progress.
- wdog_err  out  1  sticky timeout flag. Present only with the optional feature; tied 0 otherwise.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, enable_tx=0, tx_data=0, req_ready=0, grant_id=0, locked=0, rr_ptr=0, wdog_err=0. The UART itself is not reset by this block, so a frame already on the line finishes on its own.
- States: IDLE, START, WAIT.
- Selection in IDLE, computed combinationally:
  - If locked=1, sel=grant_id and only that requester is eligible.
  - Otherwise sel is the first index with req_valid high, searching rr_ptr, rr_ptr+1, ... with wrap modulo NUM_REQ.
- req_ready[i] = (state==IDLE) & any eligible valid & (i==sel). It is combinational, one-hot, and never high outside IDLE.
- IDLE transition, on an edge where req_valid[sel] & req_ready[sel]:
  - tx_data <= req_data[sel]; last_q <= req_last[sel].
  - grant_id <= sel; locked <= 1.
  - Next state START.
- IDLE while locked with the owner's valid low: stay in IDLE and keep waiting. Other requesters are starved until the owner's last byte.
- START: enable_tx=1 for exactly this one cycle, then WAIT. A tx_done seen during START is ignored.
- WAIT: on tx_done go to IDLE.
  - If last_q=1: locked <= 0 and rr_ptr <= (grant_id+1) mod NUM_REQ.
  - Otherwise the lock is held.
- Latency: byte accepted at edge N → enable_tx high in cycle N+1 → tx_data frozen until tx_done. Next accept is possible in the cycle after tx_done (1 idle cycle).
- Single-byte message (valid & last together): granted, sent, released. rr_ptr advances.
- Simultaneous requests with rr_ptr=0 and valid=4'b1010: requester 1 wins; rr_ptr then becomes 2.
- NUM_REQ not a power of two: rr_ptr wraps at NUM_REQ, never reaching indices >= NUM_REQ.

Optional Feature:
- Macro: UART_TX_ARB_WDOG_EN.
- When defined:
  - A counter runs in WAIT and clears on entry to WAIT.
  - If it reaches WDOG_CYCLES without tx_done: wdog_err <= 1 (sticky until rst), locked <= 0, rr_ptr advances past the owner, state <= IDLE.
  - The remainder of the owner's message is then treated as a new message.
- When undefined: no counter, WAIT lasts indefinitely, wdog_err is constant 0.

Test Plan:
- Single requester 0 sends "OK\r\n" with last on '\n' → 4 enable_tx pulses, tx_data 0x4F, 0x4B, 0x0D, 0x0A in order; locked falls after the 4th tx_done; rr_ptr=1.
- Requesters 0 and 2 both valid with 3-byte messages, rr_ptr=0 → all 3 bytes of req 0 go first, then all 3 of req 2; no interleaving; grant_id 0 then 2.
- Requester 1 holds the lock but drops valid for 50 cycles while requester 3 is valid → req_ready[3] stays 0 throughout; req 1 resumes and finishes; then req 3 is granted.
- tx_done pulsed in the START cycle → ignored; the block stays in WAIT until the next tx_done.
- rst asserted during WAIT → all outputs return to reset values asynchronously; after release, a fresh request is granted from rr_ptr=0.
- UART_TX_ARB_WDOG_EN defined, WDOG_CYCLES=100, tx_done withheld → wdog_err=1 at cycle 100 of WAIT; state returns to IDLE; another valid requester is granted next.
